prog_loader: RTL and testbench

Boot-time program loader that sits between an external word stream (debug or UART bridge) and the single-cycle MIPS core's instruction memory. It holds the core in reset, streams a program of `loadLen` words into instruction memory via a valid/ready handshake, keeps reset asserted for a settle window, then releases the core so its PC starts at 0. It is the driving end of the core's reset/PC-start interface: the block that decides when the core runs.

---
 rtl/loader_pkg.sv | 15 +
 rtl/prog_loader.sv | 150 +++++++++++++++
 tb/tb_prog_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states and default widths.
package loader_pkg;

  localparam int unsigned LOADER_ADDR_W   = 8;
  localparam int unsigned LOADER_DATA_W   = 32;
  localparam int unsigned LOADER_HOLD_CYC = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Streams a program into instruction memory while holding the core in reset; write 1 cycle after handshake, 1 word/cycle.
// inReady is high only in LOAD; the core is released HOLD_CYC+1 cycles after the last word. Optional LOADER_CHECKSUM_EN adds a word sum on csum.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = LOADER_ADDR_W,
  parameter int unsigned DATA_W   = LOADER_DATA_W,
  parameter int unsigned HOLD_CYC = LOADER_HOLD_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadStart,
  input  logic [ADDR_W:0]   loadLen,
  input  logic              inValid,
  input  logic [DATA_W-1:0] inData,
  output logic              inReady,
  output logic              imemWe,
  output logic [ADDR_W-1:0] imemAddr,
  output logic [DATA_W-1:0] imemData,
  output logic              cpuRst,
  output logic              busy,
  output logic              loadDone,
  output logic [31:0]       csum
);

  localparam int unsigned   HOLD_W  = $clog2(HOLD_CYC + 1);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W:0]     len_clamp;
  logic                last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]         csum_q, csum_d;
`endif

  assign len_clamp = (loadLen > MAX_LEN) ? MAX_LEN : loadLen;
  assign last_word = ((count_q + (ADDR_W+1)'(1)) == len_q);
  assign inReady   = (state_q == LOAD);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    hold_d    = hold_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      IDLE, RUN: begin
        if (loadStart) begin
          len_d     = len_clamp;
          count_d   = '0;
          hold_d    = '0;
          cpu_rst_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d    = '0;
`endif
          state_d   = (len_clamp == '0) ? HOLD : LOAD;
        end
      end
      LOAD: begin
        if (inValid) begin
          we_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          data_d  = inData;
          count_d = count_q + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q + 32'(inData);
`endif
          if (last_word) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // hold_q counts 1..HOLD_CYC after entry, so release lands HOLD_CYC+1 edges after the last word
        if (hold_q == HOLD_W'(HOLD_CYC)) begin
          state_d   = RUN;
          cpu_rst_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
  assign csum = csum_q;
`else
  assign csum = '0;
`endif

  assign imemWe   = we_q;
  assign imemAddr = addr_q;
  assign imemData = data_q;
  assign cpuRst   = cpu_rst_q;
  assign busy     = busy_q;
  assign loadDone = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: write sequencing, release timing, clamping, ignored requests and mid-load reset.
module tb_prog_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              loadStart;
  logic [ADDR_W:0]   loadLen;
  logic              inValid;
  logic [DATA_W-1:0] inData;
  logic              inReady;
  logic              imemWe;
  logic [ADDR_W-1:0] imemAddr;
  logic [DATA_W-1:0] imemData;
  logic              cpuRst;
  logic              busy;
  logic              loadDone;
  logic [31:0]       csum;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYC(4)) dut (
    .clk(clk), .rst(rst), .loadStart(loadStart), .loadLen(loadLen),
    .inValid(inValid), .inData(inData), .inReady(inReady),
    .imemWe(imemWe), .imemAddr(imemAddr), .imemData(imemData),
    .cpuRst(cpuRst), .busy(busy), .loadDone(loadDone), .csum(csum)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Edge index: cyc holds the index of the next rising edge.
  int cyc = 0;
  int hs_edge = -1;
  always @(posedge clk) begin
    if (inValid && inReady) hs_edge <= cyc;
    cyc <= cyc + 1;
  end

  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  int   done_cnt = 0;
  int   done_edge = -1;
  logic rst_at_done = 1'b1;
  logic rst_before_done = 1'b0;
  logic prev_rst = 1'b1;
  always @(negedge clk) begin
    if (imemWe) begin
      wr_addr.push_back(imemAddr);
      wr_data.push_back(imemData);
    end
    if (loadDone) begin
      done_cnt++;
      done_edge       = cyc - 1;
      rst_at_done     = cpuRst;
      rst_before_done = prev_rst;
    end
    prev_rst = cpuRst;
  end

  int start_edge = -1;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic start_load(input logic [ADDR_W:0] len);
    loadLen    = len;
    loadStart  = 1'b1;
    start_edge = cyc;
    tick();
    loadStart  = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] w);
    int t;
    t = 0;
    while (!inReady && t < 50) begin
      tick();
      t++;
    end
    if (!inReady) check("send_ready_timeout", 32'(inReady), 32'd1);
    inValid = 1'b1;
    inData  = w;
    tick();
    inValid = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int t;
    t = 0;
    while (done_cnt == prev && t < 400) begin
      tick();
      t++;
    end
    check("done_seen", 32'(done_cnt), 32'(prev + 1));
  endtask

  logic [31:0] prog [3] = '{32'h20080005, 32'h20090003, 32'h01095020};
  logic [31:0] exp_sum;
  int d0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; loadStart = 1'b0; loadLen = '0; inValid = 1'b0; inData = '0;
    tick(); tick();
    check("rst_cpuRst", 32'(cpuRst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_inReady", 32'(inReady), 32'd0);
    check("rst_addr", 32'(imemAddr), 32'd0);
    check("rst_csum", csum, 32'd0);
    rst = 1'b1;

    // Idle with a valid stream present: nothing is accepted or written
    inValid = 1'b1; inData = 32'hCAFEF00D;
    repeat (20) tick();
    inValid = 1'b0;
    check("idle_writes", 32'(wr_addr.size()), 32'd0);
    check("idle_cpuRst", 32'(cpuRst), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Three back-to-back words
    clear_writes(); d0 = done_cnt;
    start_load(9'd3);
    check("l3_busy", 32'(busy), 32'd1);
    check("l3_inReady", 32'(inReady), 32'd1);
    for (int i = 0; i < 3; i++) send(prog[i]);
    wait_done(d0);
    check("l3_nwr", 32'(wr_addr.size()), 32'd3);
    exp_sum = '0;
    for (int i = 0; i < 3; i++) begin
      exp_sum = exp_sum + prog[i];
      if (i < wr_addr.size()) begin
        check("l3_addr", 32'(wr_addr[i]), 32'(i));
        check("l3_data", wr_data[i], prog[i]);
      end
    end
    check("l3_release_lat", 32'(done_edge - hs_edge), 32'd5);
    check("l3_cpuRst_at_done", 32'(rst_at_done), 32'd0);
    check("l3_cpuRst_before", 32'(rst_before_done), 32'd1);
`ifdef LOADER_CHECKSUM_EN
    check("l3_csum", csum, exp_sum);
`else
    check("l3_csum", csum, 32'd0);
`endif
    check("l3_done_hi", 32'(loadDone), 32'd1);
    tick();
    check("l3_done_pulse", 32'(loadDone), 32'd0);
    check("l3_run_busy", 32'(busy), 32'd0);
    check("l3_run_cpuRst", 32'(cpuRst), 32'd0);

    // Gapped stream from RUN, len=2
    clear_writes(); d0 = done_cnt;
    start_load(9'd2);
    check("gap_cpuRst_reassert", 32'(cpuRst), 32'd1);
    check("gap_csum_clear", csum, 32'd0);
    send(32'h11111111);
    tick();
    send(32'h22222222);
    tick();
    wait_done(d0);
    check("gap_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("gap_addr0", 32'(wr_addr[0]), 32'd0);
      check("gap_addr1", 32'(wr_addr[1]), 32'd1);
      check("gap_data1", wr_data[1], 32'h22222222);
    end

    // Zero-length load goes straight to HOLD
    clear_writes(); d0 = done_cnt;
    start_load(9'd0);
    check("z_inReady", 32'(inReady), 32'd0);
    check("z_busy", 32'(busy), 32'd1);
    wait_done(d0);
    check("z_release_lat", 32'(done_edge - start_edge), 32'd5);
    check("z_nwr", 32'(wr_addr.size()), 32'd0);

    // loadStart during LOAD is ignored; stream after release is ignored
    clear_writes(); d0 = done_cnt;
    start_load(9'd4);
    send(32'hA0000000);
    start_load(9'd9);
    for (int i = 1; i < 4; i++) send(32'hA0000000 + 32'(i));
    wait_done(d0);
    inValid = 1'b1; inData = 32'h55555555;
    repeat (10) tick();
    inValid = 1'b0;
    check("ign_nwr", 32'(wr_addr.size()), 32'd4);
    if (wr_addr.size() == 4) check("ign_last_addr", 32'(wr_addr[3]), 32'd3);
    check("ign_done_count", 32'(done_cnt), 32'(d0 + 1));

    // Asynchronous reset mid-load, then a fresh single-word load
    start_load(9'd5);
    send(32'hBBBB0000);
    send(32'hBBBB0001);
    rst = 1'b0;
    #1;
    check("mid_rst_cpuRst", 32'(cpuRst), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_inReady", 32'(inReady), 32'd0);
    check("mid_rst_we", 32'(imemWe), 32'd0);
    check("mid_rst_addr", 32'(imemAddr), 32'd0);
    check("mid_rst_csum", csum, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    clear_writes(); d0 = done_cnt;
    start_load(9'd1);
    send(32'hDEADBEEF);
    wait_done(d0);
    check("r1_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("r1_addr", 32'(wr_addr[0]), 32'd0);
      check("r1_data", wr_data[0], 32'hDEADBEEF);
    end

    // Oversized length clamps to 256 words with no address wrap
    clear_writes(); d0 = done_cnt;
    exp_sum = '0;
    start_load(9'h1FF);
    for (int i = 0; i < 300; i++) begin
      inValid = 1'b1;
      inData  = 32'(i);
      if (i < 256) exp_sum = exp_sum + 32'(i);
      tick();
    end
    inValid = 1'b0;
    wait_done(d0);
    check("clamp_nwr", 32'(wr_addr.size()), 32'd256);
    if (wr_addr.size() == 256) begin
      check("clamp_first_addr", 32'(wr_addr[0]), 32'd0);
      check("clamp_last_addr", 32'(wr_addr[255]), 32'd255);
      check("clamp_last_data", wr_data[255], 32'd255);
    end
`ifdef LOADER_CHECKSUM_EN
    check("clamp_csum", csum, exp_sum);
`else
    check("clamp_csum", csum, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
